mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multicycle control FSM for the MIPS core.
- Decodes the instruction register fields and drives every select and enable that the datapath next-PC/operand/writeback logic consumes: brnch, jmp, regDst, aluSrc, mem2Reg.
- Also drives the register-file, IR, PC and memory enables.
- Handshakes with instruction/data memory through a ready signal, so memory latency is arbitrary.

Parameters:
- OPW, 6, opcode/funct field width.
- ALUCW, 3, ALU control width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- op  input  6  inst[31:26] from IR.
- funct  input  6  inst[5:0] from IR.
- zero  input  1  ALU zero flag.
- memRdy  input  1  memory completes current read/write this cycle.
- memRead  output  1  memory read request.
- memWrite  output  1  memory write request.
- irWrite  output  1  load IR from rData.
- pcWrite  output  1  load PC from pcp; doubles as instruction-retire pulse.
- brnch  output  1  select branch target.
- jmp  output  1  select jump target.
- regDst  output  1  write register rd (1) / rt (0).
- aluSrc  output  1  ALU B = seimm (1) / rd2 (0).
- mem2Reg  output  1  writeback = rData (1) / aluRslt (0).
- regWrite  output  1  register-file write enable.
- aluCtl  output  3  ALU operation.
- illegal  output  1  one-cycle pulse on unsupported op/funct.

Behaviour:
- State is registered; outputs are decoded from state, with some gated by zero/memRdy. Any output not listed for a state is 0.
- aluCtl encoding: AND=000, OR=001, ADD=010, SUB=110, SLT=111. aluCtl defaults to ADD.
- Reset (async, any state, mid-instruction included): state <= FETCH. While rst is high, all enables/selects are 0 and aluCtl=010. No memory access is left pending; the requester simply restarts the fetch.
- FETCH:
  - memRead=1.
  - Hold while memRdy=0.
  - When memRdy=1: irWrite=1 that cycle, then go to DECODE.
- DECODE: no enables; next state by op:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - anything else -> ILLEGAL
- MEMADR: aluSrc=1, aluCtl=010. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: memRead=1. Hold until memRdy, then MEMWB.
- MEMWB: regWrite=1, mem2Reg=1, regDst=0, pcWrite=1 -> FETCH.
- MEMWR:
  - memWrite=1, aluSrc=1, aluCtl=010.
  - Hold until memRdy. On the memRdy cycle pcWrite=1, then FETCH.
- EXEC:
  - aluSrc=0.
  - funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Valid funct -> ALUWB; any other funct -> ILLEGAL.
- ALUWB: regWrite=1, regDst=1, mem2Reg=0, aluCtl held from funct, pcWrite=1 -> FETCH.
- BRANCH: aluSrc=0, aluCtl=110, brnch=zero, pcWrite=1 -> FETCH. When not taken, pcp is PC+4.
- ADDIEX: aluSrc=1, aluCtl=010 -> ADDIWB.
- ADDIWB: regWrite=1, regDst=0, aluSrc=1, aluCtl=010, pcWrite=1 -> FETCH.
- JUMP: jmp=1, pcWrite=1 -> FETCH.
- ILLEGAL: illegal=1, pcWrite=1 (skip to PC+4), no register or memory write -> FETCH.
- Invariants:
  - brnch and jmp are never both 1.
  - memRead and memWrite are never both 1.
  - pcWrite is exactly one pulse per instruction.
- Latency in cycles with memRdy tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each memRdy=0 cycle adds one cycle in FETCH, MEMRD or MEMWR.
- The next state is undefined-free: unused encodings go to FETCH.

Optional Feature:
- Macro: MIPS_MC_CTRL_BNE_EN.
- Defined: op 000101 goes from DECODE to BRANCH with the sense inverted, brnch=~zero. A registered 1-bit flag captured in DECODE selects the polarity.
- Undefined: op 000101 is routed to ILLEGAL.

Test Plan:
- Reset: assert rst mid-MEMRD -> all outputs 0 immediately; after release, memRead=1 in FETCH within the same cycle.
- lw (op=100011), memRdy held 0 for 3 cycles in MEMRD -> memRead high 4 cycles, then one MEMWB cycle with regWrite=1, mem2Reg=1, pcWrite=1; total 8 cycles.
- R-type sub (op=0, funct=100010), memRdy=1 -> aluCtl=110 in EXEC and ALUWB, regDst=1, regWrite=1 in cycle 4, single pcWrite pulse.
- beq with zero=1 then zero=0 -> BRANCH cycle shows brnch=1/pcWrite=1, then brnch=0/pcWrite=1; regWrite and memWrite stay 0.
- j (op=000010) -> jmp=1, pcWrite=1 in cycle 3, brnch=0.
- op=111111 and R-type funct=001000 -> illegal pulse 1 cycle, pcWrite=1, regWrite=0. With MIPS_MC_CTRL_BNE_EN, op=000101 and zero=0 -> brnch=1.

Source files
------------

// File: rtl/mips_mc_ctrl_if.sv
// Control-side bus of the multicycle MIPS controller.
// Groups the instruction fields, flags and memory handshake that the
// controller consumes with every select/enable it drives into the datapath.
//
// Memory handshake: memRead/memWrite is a request that stays asserted,
// unchanged, until the memory answers with memRdy=1; the transfer completes
// on the clock edge that ends the cycle where request and memRdy are both 1.
// memRdy is ignored in cycles without a request.
interface mips_mc_ctrl_if #(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
);
    // Instruction fields and status into the controller
    logic [OPW-1:0]   op;
    logic [OPW-1:0]   funct;
    logic             zero;
    logic             memRdy;

    // Enables and selects out of the controller
    logic             memRead;
    logic             memWrite;
    logic             irWrite;
    logic             pcWrite;
    logic             brnch;
    logic             jmp;
    logic             regDst;
    logic             aluSrc;
    logic             mem2Reg;
    logic             regWrite;
    logic [ALUCW-1:0] aluCtl;
    logic             illegal;

    // Controller side
    modport master (
        input  op, funct, zero, memRdy,
        output memRead, memWrite, irWrite, pcWrite, brnch, jmp,
               regDst, aluSrc, mem2Reg, regWrite, aluCtl, illegal
    );

    // Datapath / memory side
    modport slave (
        output op, funct, zero, memRdy,
        input  memRead, memWrite, irWrite, pcWrite, brnch, jmp,
               regDst, aluSrc, mem2Reg, regWrite, aluCtl, illegal
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM for the MIPS core.
// Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j; everything
// else retires through the ILLEGAL state (illegal pulse, PC+4, no writes).
// Optional build macro MIPS_MC_CTRL_BNE_EN adds bne (op 000101): it shares
// the BRANCH state with beq, with the taken sense inverted by a flag
// captured in DECODE. Without the macro, op 000101 is illegal.
// Outputs are decoded from the registered state; irWrite and the sw
// pcWrite are additionally gated by memRdy and brnch by the ALU zero flag.
// dbg_state exposes the current state encoding for monitoring.
module mips_mc_ctrl #(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
) (
    input  logic           clk,
    input  logic           rst,
    mips_mc_ctrl_if.master bus,
    output logic [3:0]     dbg_state
);

    // Opcodes
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    // R-type function codes
    localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
    localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
    localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
    localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
    localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);

    // ALU operations
    localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(3'b000);
    localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(3'b001);
    localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(3'b010);
    localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(3'b110);
    localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(3'b111);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    state_t           state_q, state_d;
    // ALU operation decoded in EXEC, held for the ALUWB cycle
    logic [ALUCW-1:0] alu_ctl_q, alu_ctl_d;
    logic             funct_ok;
    logic [ALUCW-1:0] funct_alu;
    logic             branch_taken;

`ifdef MIPS_MC_CTRL_BNE_EN
    // Branch polarity: 1 = bne (taken when not zero), 0 = beq
    logic bne_q, bne_d;
    assign branch_taken = bne_q ? ~bus.zero : bus.zero;
`else
    assign branch_taken = bus.zero;
`endif

    assign dbg_state = state_q;

    // Decode the R-type function field into an ALU operation and validity
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic; unused state encodings fall back to FETCH
    always_comb begin
        state_d   = state_q;
        alu_ctl_d = alu_ctl_q;
`ifdef MIPS_MC_CTRL_BNE_EN
        bne_d     = bne_q;
`endif
        case (state_q)
            S_FETCH:  if (bus.memRdy) state_d = S_DECODE;
            S_DECODE: begin
`ifdef MIPS_MC_CTRL_BNE_EN
                bne_d = (bus.op == OP_BNE);
`endif
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.memRdy) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.memRdy) state_d = S_FETCH;
            S_EXEC: begin
                alu_ctl_d = funct_alu;
                state_d   = funct_ok ? S_ALUWB : S_ILLEGAL;
            end
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // State and captured decode registers; reset restarts the fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            alu_ctl_q <= ALU_ADD;
`ifdef MIPS_MC_CTRL_BNE_EN
            bne_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            alu_ctl_q <= alu_ctl_d;
`ifdef MIPS_MC_CTRL_BNE_EN
            bne_q     <= bne_d;
`endif
        end
    end

    // Output decode from state; everything is forced idle while rst is high
    always_comb begin
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.irWrite  = 1'b0;
        bus.pcWrite  = 1'b0;
        bus.brnch    = 1'b0;
        bus.jmp      = 1'b0;
        bus.regDst   = 1'b0;
        bus.aluSrc   = 1'b0;
        bus.mem2Reg  = 1'b0;
        bus.regWrite = 1'b0;
        bus.aluCtl   = ALU_ADD;
        bus.illegal  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.memRead = 1'b1;
                    bus.irWrite = bus.memRdy;
                end
                S_MEMADR: bus.aluSrc = 1'b1;
                S_MEMRD:  bus.memRead = 1'b1;
                S_MEMWB: begin
                    bus.regWrite = 1'b1;
                    bus.mem2Reg  = 1'b1;
                    bus.pcWrite  = 1'b1;
                end
                S_MEMWR: begin
                    bus.memWrite = 1'b1;
                    bus.aluSrc   = 1'b1;
                    bus.pcWrite  = bus.memRdy;
                end
                S_EXEC: bus.aluCtl = funct_alu;
                S_ALUWB: begin
                    bus.regWrite = 1'b1;
                    bus.regDst   = 1'b1;
                    bus.aluCtl   = alu_ctl_q;
                    bus.pcWrite  = 1'b1;
                end
                S_BRANCH: begin
                    bus.aluCtl  = ALU_SUB;
                    bus.brnch   = branch_taken;
                    bus.pcWrite = 1'b1;
                end
                S_ADDIEX: bus.aluSrc = 1'b1;
                S_ADDIWB: begin
                    bus.regWrite = 1'b1;
                    bus.aluSrc   = 1'b1;
                    bus.pcWrite  = 1'b1;
                end
                S_JUMP: begin
                    bus.jmp     = 1'b1;
                    bus.pcWrite = 1'b1;
                end
                S_ILLEGAL: begin
                    bus.illegal = 1'b1;
                    bus.pcWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. A memory responder answers each
// request after a chosen number of wait cycles; a transaction-level model
// predicts per-instruction cycle count, enable counts and writeback selects.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dbg_state;

    // Clock
    always #5 clk = ~clk;

    mips_mc_ctrl_if #(.OPW(6), .ALUCW(3)) bus ();

    mips_mc_ctrl #(.OPW(6), .ALUCW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       brnch;
        logic       jmp;
        logic       reg_dst;
        logic       alu_src;
        logic       mem2reg;
        logic       reg_write;
        logic [2:0] alu_ctl;
        logic       illegal;
    } smp_t;

    typedef struct {
        int         cycles;
        int         rd_cnt;
        int         wr_cnt;
        int         ir_cnt;
        int         rw_cnt;
        int         br_cnt;
        int         jmp_cnt;
        int         ill_cnt;
        int         inv_err;
        logic       rw_dst;
        logic       rw_m2r;
        logic       rw_src;
        logic [2:0] alu_at_pc;
    } sum_t;

    smp_t tr [64];
    int   n_cyc;
    logic timeout;

    logic [5:0] valid_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Pulse reset away from the clock edge and leave the FSM in FETCH
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        bus.memRdy = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Drive one instruction; memory answers fetch after lf waits, data after ld waits
    task automatic exec_instr(input logic [5:0] op_i, input logic [5:0] funct_i,
                              input logic zero_i, input int lf, input int ld);
        logic fetched;
        logic req;
        int   wl;
        bus.op    = op_i;
        bus.funct = funct_i;
        bus.zero  = zero_i;
        fetched = 1'b0;
        req     = 1'b0;
        wl      = 0;
        n_cyc   = 0;
        timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.memRead || bus.memWrite) begin
                if (!req) begin
                    req = 1'b1;
                    wl  = fetched ? ld : lf;
                end
                if (wl == 0) begin
                    bus.memRdy = 1'b1;
                    req        = 1'b0;
                end else begin
                    bus.memRdy = 1'b0;
                    wl--;
                end
            end else begin
                bus.memRdy = 1'($urandom_range(0, 1));
            end
            #1;
            tr[n_cyc] = '{bus.memRead, bus.memWrite, bus.irWrite, bus.pcWrite, bus.brnch,
                          bus.jmp, bus.regDst, bus.aluSrc, bus.mem2Reg, bus.regWrite,
                          bus.aluCtl, bus.illegal};
            n_cyc++;
            if (bus.irWrite) fetched = 1'b1;
            if (bus.pcWrite) begin
                timeout = 1'b0;
                break;
            end
        end
        checks++;
        if (timeout) begin
            failures++;
            $display("FAIL timeout op=%b funct=%b: no pcWrite within 40 cycles (state=%0d), required one", op_i, funct_i, dbg_state);
            do_reset();
        end
    endtask

    // Reduce the recorded trace to per-instruction totals
    function automatic sum_t summarize();
        sum_t s;
        s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 3'b000};
        s.cycles = n_cyc;
        for (int i = 0; i < n_cyc; i++) begin
            s.rd_cnt  += int'(tr[i].mem_read);
            s.wr_cnt  += int'(tr[i].mem_write);
            s.ir_cnt  += int'(tr[i].ir_write);
            s.rw_cnt  += int'(tr[i].reg_write);
            s.br_cnt  += int'(tr[i].brnch);
            s.jmp_cnt += int'(tr[i].jmp);
            s.ill_cnt += int'(tr[i].illegal);
            s.inv_err += int'(tr[i].brnch & tr[i].jmp) + int'(tr[i].mem_read & tr[i].mem_write);
            if (tr[i].reg_write) begin
                s.rw_dst = tr[i].reg_dst;
                s.rw_m2r = tr[i].mem2reg;
                s.rw_src = tr[i].alu_src;
            end
        end
        if (n_cyc > 0) s.alu_at_pc = tr[n_cyc-1].alu_ctl;
        return s;
    endfunction

    // Instruction-level reference: latency table plus one fetch and data access
    function automatic sum_t model(input logic [5:0] op, input logic [5:0] funct,
                                   input logic zero, input int lf, input int ld);
        sum_t e;
        logic       ok;
        logic [2:0] a;
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 3'b010};
        e.ir_cnt = 1;
        e.rd_cnt = lf + 1;
        case (op)
            6'b100011: begin
                e.cycles = 5 + lf + ld;
                e.rd_cnt += ld + 1;
                e.rw_cnt = 1;
                e.rw_m2r = 1'b1;
            end
            6'b101011: begin
                e.cycles = 4 + lf + ld;
                e.wr_cnt = ld + 1;
            end
            6'b000000: begin
                ok = 1'b1;
                a  = 3'b010;
                case (funct)
                    6'b100000: a = 3'b010;
                    6'b100010: a = 3'b110;
                    6'b100100: a = 3'b000;
                    6'b100101: a = 3'b001;
                    6'b101010: a = 3'b111;
                    default:   ok = 1'b0;
                endcase
                e.cycles = 4 + lf;
                if (ok) begin
                    e.rw_cnt    = 1;
                    e.rw_dst    = 1'b1;
                    e.alu_at_pc = a;
                end else begin
                    e.ill_cnt = 1;
                end
            end
            6'b000100: begin
                e.cycles    = 3 + lf;
                e.br_cnt    = zero ? 1 : 0;
                e.alu_at_pc = 3'b110;
            end
`ifdef MIPS_MC_CTRL_BNE_EN
            6'b000101: begin
                e.cycles    = 3 + lf;
                e.br_cnt    = zero ? 0 : 1;
                e.alu_at_pc = 3'b110;
            end
`endif
            6'b001000: begin
                e.cycles = 4 + lf;
                e.rw_cnt = 1;
                e.rw_src = 1'b1;
            end
            6'b000010: begin
                e.cycles  = 3 + lf;
                e.jmp_cnt = 1;
            end
            default: begin
                e.cycles  = 3 + lf;
                e.ill_cnt = 1;
            end
        endcase
        return e;
    endfunction

    // Reset at start and in the middle of a data read
    task automatic test_reset();
        logic [10:0] outs;
        rst = 1'b1;
        bus.memRdy = 1'b0;
        bus.op = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        outs = {bus.memRead, bus.memWrite, bus.irWrite, bus.pcWrite, bus.brnch, bus.jmp,
                bus.regDst, bus.aluSrc, bus.mem2Reg, bus.regWrite, bus.illegal};
        checks++;
        if (outs !== 11'd0) begin failures++; $display("FAIL reset_outs got=%b want=0", outs); end
        checks++;
        if (bus.aluCtl !== 3'b010) begin failures++; $display("FAIL reset_aluctl got=%b want=010", bus.aluCtl); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.memRead !== 1'b1 || bus.irWrite !== 1'b0) begin
            failures++; $display("FAIL reset_release_fetch memRead=%b irWrite=%b want 1/0", bus.memRead, bus.irWrite);
        end
        // Walk a lw into MEMRD with the data access stalled, then reset there
        @(negedge clk); bus.memRdy = 1'b1;
        @(negedge clk); bus.memRdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.aluSrc !== 1'b0) begin
            failures++; $display("FAIL memrd_before_reset memRead=%b memWrite=%b aluSrc=%b want 1/0/0", bus.memRead, bus.memWrite, bus.aluSrc);
        end
        #2 rst = 1'b1;
        #1;
        outs = {bus.memRead, bus.memWrite, bus.irWrite, bus.pcWrite, bus.brnch, bus.jmp,
                bus.regDst, bus.aluSrc, bus.mem2Reg, bus.regWrite, bus.illegal};
        checks++;
        if (outs !== 11'd0 || bus.aluCtl !== 3'b010) begin
            failures++; $display("FAIL reset_mid_memrd outs=%b aluCtl=%b want 0/010", outs, bus.aluCtl);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.memRead !== 1'b1) begin failures++; $display("FAIL reset_restart_fetch memRead=%b want 1", bus.memRead); end
    endtask

    // lw with three data wait cycles
    task automatic test_lw_stall();
        int rd_in_memrd;
        exec_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
        checks++;
        if (n_cyc !== 8) begin failures++; $display("FAIL lw_cycles got=%0d want=8", n_cyc); end
        rd_in_memrd = 0;
        for (int i = 3; i < 7; i++) rd_in_memrd += int'(tr[i].mem_read);
        checks++;
        if (rd_in_memrd !== 4) begin failures++; $display("FAIL lw_memrd_cycles got=%0d want=4", rd_in_memrd); end
        checks++;
        if (tr[7].reg_write !== 1'b1 || tr[7].mem2reg !== 1'b1 || tr[7].pc_write !== 1'b1 || tr[7].reg_dst !== 1'b0) begin
            failures++; $display("FAIL lw_memwb regWrite=%b mem2Reg=%b pcWrite=%b regDst=%b want 1/1/1/0", tr[7].reg_write, tr[7].mem2reg, tr[7].pc_write, tr[7].reg_dst);
        end
        checks++;
        if (tr[2].alu_src !== 1'b1 || tr[2].alu_ctl !== 3'b010) begin
            failures++; $display("FAIL lw_memadr aluSrc=%b aluCtl=%b want 1/010", tr[2].alu_src, tr[2].alu_ctl);
        end
    endtask

    // R-type sub with no memory waits
    task automatic test_rtype_sub();
        exec_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
        checks++;
        if (n_cyc !== 4) begin failures++; $display("FAIL sub_cycles got=%0d want=4", n_cyc); end
        checks++;
        if (tr[2].alu_ctl !== 3'b110 || tr[3].alu_ctl !== 3'b110) begin
            failures++; $display("FAIL sub_aluctl exec=%b wb=%b want 110/110", tr[2].alu_ctl, tr[3].alu_ctl);
        end
        checks++;
        if (tr[3].reg_dst !== 1'b1 || tr[3].reg_write !== 1'b1 || tr[2].reg_write !== 1'b0 || tr[2].alu_src !== 1'b0) begin
            failures++; $display("FAIL sub_wb regDst=%b regWrite=%b exec_regWrite=%b exec_aluSrc=%b want 1/1/0/0", tr[3].reg_dst, tr[3].reg_write, tr[2].reg_write, tr[2].alu_src);
        end
    endtask

    // beq taken then not taken
    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            exec_instr(6'b000100, 6'b000000, 1'(z), 0, 0);
            checks++;
            if (n_cyc !== 3 || tr[2].brnch !== 1'(z) || tr[2].pc_write !== 1'b1) begin
                failures++; $display("FAIL beq_z%0d cycles=%0d brnch=%b pcWrite=%b want 3/%0d/1", z, n_cyc, tr[2].brnch, tr[2].pc_write, z);
            end
            checks++;
            if (tr[2].reg_write !== 1'b0 || tr[2].mem_write !== 1'b0 || tr[2].alu_ctl !== 3'b110) begin
                failures++; $display("FAIL beq_side_z%0d regWrite=%b memWrite=%b aluCtl=%b want 0/0/110", z, tr[2].reg_write, tr[2].mem_write, tr[2].alu_ctl);
            end
        end
    endtask

    // Unconditional jump
    task automatic test_jump();
        exec_instr(6'b000010, 6'b000000, 1'b1, 0, 0);
        checks++;
        if (n_cyc !== 3 || tr[2].jmp !== 1'b1 || tr[2].pc_write !== 1'b1 || tr[2].brnch !== 1'b0) begin
            failures++; $display("FAIL jump cycles=%0d jmp=%b pcWrite=%b brnch=%b want 3/1/1/0", n_cyc, tr[2].jmp, tr[2].pc_write, tr[2].brnch);
        end
    endtask

    // Unsupported opcode, unsupported funct, and bne
    task automatic test_illegal();
        exec_instr(6'b111111, 6'b000000, 1'b0, 1, 0);
        checks++;
        if (n_cyc !== 4 || tr[3].illegal !== 1'b1 || tr[3].pc_write !== 1'b1 || tr[3].reg_write !== 1'b0 || tr[2].illegal !== 1'b0) begin
            failures++; $display("FAIL illegal_op cycles=%0d illegal=%b pcWrite=%b regWrite=%b want 4/1/1/0", n_cyc, tr[3].illegal, tr[3].pc_write, tr[3].reg_write);
        end
        exec_instr(6'b000000, 6'b001000, 1'b0, 0, 0);
        checks++;
        if (n_cyc !== 4 || tr[3].illegal !== 1'b1 || tr[3].pc_write !== 1'b1 || tr[3].reg_write !== 1'b0 || tr[2].illegal !== 1'b0) begin
            failures++; $display("FAIL illegal_funct cycles=%0d illegal=%b pcWrite=%b regWrite=%b want 4/1/1/0", n_cyc, tr[3].illegal, tr[3].pc_write, tr[3].reg_write);
        end
        exec_instr(6'b000101, 6'b000000, 1'b0, 0, 0);
        checks++;
`ifdef MIPS_MC_CTRL_BNE_EN
        if (n_cyc !== 3 || tr[2].brnch !== 1'b1 || tr[2].illegal !== 1'b0) begin
            failures++; $display("FAIL bne_taken cycles=%0d brnch=%b illegal=%b want 3/1/0", n_cyc, tr[2].brnch, tr[2].illegal);
        end
`else
        if (n_cyc !== 3 || tr[2].brnch !== 1'b0 || tr[2].illegal !== 1'b1) begin
            failures++; $display("FAIL bne_illegal cycles=%0d brnch=%b illegal=%b want 3/0/1", n_cyc, tr[2].brnch, tr[2].illegal);
        end
`endif
    endtask

    // Random instruction stream, back to back, with random memory latency
    task automatic test_random();
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lf;
        int         ld;
        sum_t       s;
        sum_t       e;
        logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : valid_funct[$urandom_range(0, 4)];
            z  = 1'($urandom_range(0, 1));
            lf = $urandom_range(0, 3);
            ld = $urandom_range(0, 3);
            exec_instr(op, fn, z, lf, ld);
            s = summarize();
            e = model(op, fn, z, lf, ld);
            checks++;
            if (s.cycles !== e.cycles) begin failures++; $display("FAIL rnd_cycles op=%b fn=%b got=%0d want=%0d", op, fn, s.cycles, e.cycles); end
            checks++;
            if (s.rd_cnt !== e.rd_cnt) begin failures++; $display("FAIL rnd_memread op=%b got=%0d want=%0d", op, s.rd_cnt, e.rd_cnt); end
            checks++;
            if (s.wr_cnt !== e.wr_cnt) begin failures++; $display("FAIL rnd_memwrite op=%b got=%0d want=%0d", op, s.wr_cnt, e.wr_cnt); end
            checks++;
            if (s.ir_cnt !== e.ir_cnt) begin failures++; $display("FAIL rnd_irwrite op=%b got=%0d want=%0d", op, s.ir_cnt, e.ir_cnt); end
            checks++;
            if (s.rw_cnt !== e.rw_cnt) begin failures++; $display("FAIL rnd_regwrite op=%b fn=%b got=%0d want=%0d", op, fn, s.rw_cnt, e.rw_cnt); end
            checks++;
            if (s.br_cnt !== e.br_cnt) begin failures++; $display("FAIL rnd_brnch op=%b z=%b got=%0d want=%0d", op, z, s.br_cnt, e.br_cnt); end
            checks++;
            if (s.jmp_cnt !== e.jmp_cnt) begin failures++; $display("FAIL rnd_jmp op=%b got=%0d want=%0d", op, s.jmp_cnt, e.jmp_cnt); end
            checks++;
            if (s.ill_cnt !== e.ill_cnt) begin failures++; $display("FAIL rnd_illegal op=%b fn=%b got=%0d want=%0d", op, fn, s.ill_cnt, e.ill_cnt); end
            checks++;
            if (s.inv_err !== 0) begin failures++; $display("FAIL rnd_invariant op=%b conflicting cycles=%0d want=0", op, s.inv_err); end
            checks++;
            if ({s.rw_dst, s.rw_m2r, s.rw_src} !== {e.rw_dst, e.rw_m2r, e.rw_src}) begin
                failures++; $display("FAIL rnd_wb_sel op=%b dst/m2r/src got=%b%b%b want=%b%b%b", op, s.rw_dst, s.rw_m2r, s.rw_src, e.rw_dst, e.rw_m2r, e.rw_src);
            end
            checks++;
            if (s.alu_at_pc !== e.alu_at_pc) begin failures++; $display("FAIL rnd_aluctl op=%b fn=%b got=%b want=%b", op, fn, s.alu_at_pc, e.alu_at_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_rtype_sub();
        test_beq();
        test_jump();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
